// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - write/readback bus between the I/O decoder and the 7-segment scan driver
interface seg7_scan_driver_if;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [7:0]  wr_dp;
  logic [7:0]  wr_dig_en;
  logic [31:0] shown_data;

  modport master (
    output wr_en, wr_data, wr_dp, wr_dig_en,
    input  shown_data
  );

  modport slave (
    input  wr_en, wr_data, wr_dp, wr_dig_en,
    output shown_data
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 8-digit multiplexed 7-segment scanner with anti-ghost blanking; optional LEADING_ZERO_BLANK_EN
module seg7_scan_driver #(
  parameter int SCAN_DIV  = 100_000,
  parameter int BLANK_CYC = 1_000
) (
  input  logic                    clk,
  input  logic                    reset,
  seg7_scan_driver_if.slave       bus,
  output logic [7:0]              AN,
  output logic [6:0]              A2G,
  output logic                    DP
);

  localparam int CW = $clog2(SCAN_DIV);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  logic [31:0]   r_data;
  logic [7:0]    r_dp_mask;
  logic [7:0]    r_dig_en;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  state_t        r_state;
  logic [7:0]    r_an;
  logic [6:0]    r_a2g;
  logic          r_dp;

  logic [CW-1:0] w_cnt_next;
  logic [2:0]    w_idx_next;
  state_t        w_state_next;
  logic [7:0]    w_an_next;
  logic [6:0]    w_a2g_next;
  logic          w_dp_next;
  logic [7:0]    w_lit;

  function automatic logic [6:0] hexdec(input logic [3:0] v);
    case (v)
      4'h0: hexdec = 7'b0000001;
      4'h1: hexdec = 7'b1001111;
      4'h2: hexdec = 7'b0010010;
      4'h3: hexdec = 7'b0000110;
      4'h4: hexdec = 7'b1001100;
      4'h5: hexdec = 7'b0100100;
      4'h6: hexdec = 7'b0100000;
      4'h7: hexdec = 7'b0001111;
      4'h8: hexdec = 7'b0000000;
      4'h9: hexdec = 7'b0000100;
      4'hA: hexdec = 7'b0001000;
      4'hB: hexdec = 7'b1100000;
      4'hC: hexdec = 7'b0110001;
      4'hD: hexdec = 7'b1000010;
      4'hE: hexdec = 7'b0110000;
      default: hexdec = 7'b0111000;
    endcase
  endfunction

  assign bus.shown_data = r_data;
  assign AN  = r_an;
  assign A2G = r_a2g;
  assign DP  = r_dp;

  // Latch the decoder's write; independent of the scan timing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data    <= 32'h0;
      r_dp_mask <= 8'h00;
      r_dig_en  <= 8'hFF;
    end else if (bus.wr_en) begin
      r_data    <= bus.wr_data;
      r_dp_mask <= bus.wr_dp;
      r_dig_en  <= bus.wr_dig_en;
    end
  end

  // Slot counter wraps at SCAN_DIV-1 and then steps to the next digit
  always_comb begin
    w_cnt_next = r_cnt + 1'b1;
    w_idx_next = r_idx;
    if (r_cnt == CW'(SCAN_DIV - 1)) begin
      w_cnt_next = '0;
      w_idx_next = r_idx + 3'd1;
    end
  end

  // Per-digit visibility: enable mask, optionally gated by leading-zero suppression
`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    logic seen_nz;
    seen_nz = 1'b0;
    w_lit   = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      seen_nz  = seen_nz | (r_data[4*i +: 4] != 4'h0);
      w_lit[i] = r_dig_en[i] & (seen_nz | (i == 0));
    end
  end
`else
  always_comb begin
    w_lit = r_dig_en;
  end
`endif

  // Next state and next pin values; pins show the slot the counter is entering
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_BLANK: if (w_cnt_next >= CW'(BLANK_CYC)) w_state_next = ST_SHOW;
      ST_SHOW:  if (w_cnt_next <  CW'(BLANK_CYC)) w_state_next = ST_BLANK;
      default:  w_state_next = ST_BLANK;
    endcase
    w_an_next  = 8'hFF;
    w_a2g_next = 7'h7F;
    w_dp_next  = 1'b1;
    if (w_state_next == ST_SHOW && w_lit[w_idx_next]) begin
      w_an_next  = ~(8'b1 << w_idx_next);
      w_a2g_next = hexdec(r_data[{w_idx_next, 2'b00} +: 4]);
      w_dp_next  = ~r_dp_mask[w_idx_next];
    end
  end

  // Scan position, FSM state and registered pin drivers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_state <= ST_BLANK;
      r_an    <= 8'hFF;
      r_a2g   <= 7'h7F;
      r_dp    <= 1'b1;
    end else begin
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_state <= w_state_next;
      r_an    <= w_an_next;
      r_a2g   <= w_a2g_next;
      r_dp    <= w_dp_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver with a frame-arithmetic reference model
module tb_seg7_scan_driver;

  localparam int SD = 8;
  localparam int BC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] an;
  logic [6:0] a2g;
  logic       dp;

  seg7_scan_driver_if bus_if();

  seg7_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .AN    (an),
    .A2G   (a2g),
    .DP    (dp)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tab [16];
  int         vectors = 0;
  int         miscompares = 0;
  int         n = 0;
  logic [31:0] m_data;
  logic [7:0]  m_dp;
  logic [7:0]  m_en;
  logic [7:0]  e_an;
  logic [6:0]  e_a2g;
  logic        e_dp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h at n=%0d", tag, obs, exp_v, n);
    end
  endtask

  task automatic model_reset();
    n = 0; m_data = 32'h0; m_dp = 8'h00; m_en = 8'hFF;
  endtask

  // One clock: predict pins from the scan position n, then latch any write for later edges
  task automatic tick();
    int  cnt, idx;
    logic lit;
    @(posedge clk);
    n++;
    cnt = n % SD;
    idx = (n / SD) % 8;
    lit = m_en[idx];
`ifdef LEADING_ZERO_BLANK_EN
    if (idx != 0 && (m_data >> (4 * idx)) == 32'h0) lit = 1'b0;
`endif
    if (cnt < BC || !lit) begin
      e_an = 8'hFF; e_a2g = 7'h7F; e_dp = 1'b1;
    end else begin
      e_an  = ~(8'h01 << idx);
      e_a2g = hex_tab[(m_data >> (4 * idx)) & 32'hF];
      e_dp  = ~m_dp[idx];
    end
    if (bus_if.wr_en) begin
      m_data = bus_if.wr_data; m_dp = bus_if.wr_dp; m_en = bus_if.wr_dig_en;
    end
    @(negedge clk);
    chk("AN", {24'h0, an}, {24'h0, e_an});
    chk("A2G", {25'h0, a2g}, {25'h0, e_a2g});
    chk("DP", {31'h0, dp}, {31'h0, e_dp});
    chk("shown_data", bus_if.shown_data, m_data);
  endtask

  task automatic do_write(input logic [31:0] d, input logic [7:0] p, input logic [7:0] e);
    bus_if.wr_en = 1'b1; bus_if.wr_data = d; bus_if.wr_dp = p; bus_if.wr_dig_en = e;
    tick();
    bus_if.wr_en = 1'b0;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic check_reset_pins(input string tag);
    chk({tag, "_AN"}, {24'h0, an}, 32'hFF);
    chk({tag, "_A2G"}, {25'h0, a2g}, 32'h7F);
    chk({tag, "_DP"}, {31'h0, dp}, 32'h1);
    chk({tag, "_shown"}, bus_if.shown_data, 32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    bit          found;
    hex_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    bus_if.wr_en = 1'b0; bus_if.wr_data = 32'h0; bus_if.wr_dp = 8'h0; bus_if.wr_dig_en = 8'h0;
    model_reset();

    // Reset state and first slot after release
    repeat (3) @(negedge clk);
    check_reset_pins("reset");
    reset = 1'b0;
    run(SD + 4);

    // Full walk over all digits with a distinct hex word, through the 7->0 wrap
    do_write(32'h89ABCDEF, 8'h00, 8'hFF);
    run(8 * SD + 10);

    // Single decimal point on digit 2
    do_write(32'h89ABCDEF, 8'h04, 8'hFF);
    run(8 * SD);

    // Upper four digits disabled
    do_write(32'h01234567, 8'hF0, 8'h0F);
    run(8 * SD);

    // Leading-zero words
    do_write(32'h000000A5, 8'hFF, 8'hFF);
    run(8 * SD);
    do_write(32'h00000000, 8'h01, 8'hFF);
    run(8 * SD);

    // wr_en held high for several cycles: last write wins
    for (int i = 0; i < 5; i++) begin
      bus_if.wr_en = 1'b1; bus_if.wr_data = $urandom; bus_if.wr_dp = 8'($urandom);
      bus_if.wr_dig_en = 8'($urandom);
      tick();
    end
    bus_if.wr_en = 1'b0;
    run(2 * SD);

    // Random writes at random moments
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        rd = $urandom >> $urandom_range(0, 31);
        do_write(rd, 8'($urandom), ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom));
      end else begin
        tick();
      end
    end

    // Asynchronous reset in the middle of digit 5's SHOW phase
    do_write(32'h89ABCDEF, 8'h20, 8'hFF);
    found = 1'b0;
    for (int i = 0; i < 8 * SD + 1 && !found; i++) begin
      if ((n / SD) % 8 == 5 && n % SD == 4) found = 1'b1;
      else tick();
    end
    chk("reach_digit5", {31'h0, found}, 32'h1);
    chk("digit5_active", {24'h0, an}, 32'hDF);
    #1 reset = 1'b1;
    #1 check_reset_pins("async_reset");
    @(negedge clk);
    check_reset_pins("reset_hold");
    reset = 1'b0;
    model_reset();
    run(2 * SD + 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
